// File: rtl/adc_spi_input_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_input_capture_pkg
// Description : Shared definitions for the AD7980 SPI capture block: word
//               width, FSM state encodings, idle pin levels and the threshold
//               compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_spi_input_capture_pkg;

    localparam int c_ADC_BITS = 16;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CONV  = 2'd1;
    localparam logic [1:0] c_ST_EN    = 2'd2;
    localparam logic [1:0] c_ST_SHIFT = 2'd3;

    // Pin levels while no frame is running
    localparam logic c_CNV_IDLE  = 1'b0;
    localparam logic c_SCLK_IDLE = 1'b0;

    // Unsigned offset-binary compare; equality is a hit for both polarities.
    function automatic logic thresh_hit(
        input logic [c_ADC_BITS-1:0] word,
        input logic [c_ADC_BITS-1:0] thrsh,
        input logic                  pol_ge
    );
        return pol_ge ? (word >= thrsh) : (word <= thrsh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_input_capture_sclk_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_input_capture_sclk_phase_gen
// Description : SCLK generator for the AD7980 reader. While i_run is high it
//               produces SCLK low for SCLK_HALF cycles then high for
//               SCLK_HALF cycles, repeating, and flags the last high cycle of
//               each period as the data capture point.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_run     - high while the owning FSM is shifting
//               o_sclk    - registered SCLK level
//               o_capture - last SCLK-high cycle of the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_input_capture_sclk_phase_gen
    import adc_spi_input_capture_pkg::*;
#(
    parameter int SCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_sclk,
    output logic o_capture
);

    localparam int c_PHASE_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(SCLK_HALF - 1);

    logic [c_PHASE_W-1:0] r_phase;
    logic                 r_sclk;
    logic                 w_half_end;

    assign w_half_end = (r_phase == c_PHASE_LAST);

    // Holding the counter cleared while not running means every SHIFT entry
    // starts with a full SCLK-low half period.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_phase <= '0;
            r_sclk  <= c_SCLK_IDLE;
        end else if (w_half_end) begin
            r_phase <= '0;
            r_sclk  <= ~r_sclk;
        end else begin
            r_phase <= r_phase + c_PHASE_W'(1);
        end
    end

    assign o_sclk    = r_sclk;
    assign o_capture = i_run && r_sclk && w_half_end;

endmodule
`default_nettype wire

// File: rtl/adc_spi_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_input_capture
// Description : SPI reader for one AD7980 16-bit ADC (CS mode, 3-wire). On a
//               start strobe it raises CNV for CONV_CYCLES cycles, waits one
//               cycle for SDO enable, clocks 16 bits in MSB first and presents
//               the unsigned offset-binary word with a one-cycle valid pulse
//               and a registered threshold flag.
// Ports       : dataclk       - clock, all logic on posedge
//               reset         - synchronous active-high reset
//               ADC_en        - gates new start requests
//               start         - one-cycle convert-and-read request
//               ADC_CNV       - convert / chip select to the ADC
//               ADC_SCLK      - serial clock to the ADC
//               ADC_DATA      - SDO from the ADC
//               sample        - last captured word
//               sample_valid  - one-cycle pulse when sample updates
//               busy          - frame in progress
//               overrun       - one-cycle pulse after a dropped start
//               ADC_thrsh     - threshold word
//               ADC_thrsh_pol - 1: flag on >=, 0: flag on <=
//               ADC_thrsh_out - registered threshold flag
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_input_capture
    import adc_spi_input_capture_pkg::*;
#(
    parameter int CONV_CYCLES = 60,
    parameter int SCLK_HALF   = 2
) (
    input  logic                  dataclk,
    input  logic                  reset,
    input  logic                  ADC_en,
    input  logic                  start,
    output logic                  ADC_CNV,
    output logic                  ADC_SCLK,
    input  logic                  ADC_DATA,
    output logic [c_ADC_BITS-1:0] sample,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun,
    input  logic [c_ADC_BITS-1:0] ADC_thrsh,
    input  logic                  ADC_thrsh_pol,
    output logic                  ADC_thrsh_out
);

    localparam int c_CONV_W = $clog2(CONV_CYCLES + 1);
    localparam logic [c_CONV_W-1:0] c_CONV_LOAD = c_CONV_W'(CONV_CYCLES);
    localparam logic [c_CONV_W-1:0] c_CONV_ONE  = c_CONV_W'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_adc_data_q;
    logic [c_CONV_W-1:0]   r_conv_cnt;
    logic [3:0]            r_bit_idx;
    logic [c_ADC_BITS-2:0] r_shift;
    logic                  r_cnv;
    logic                  r_busy;
    logic                  r_overrun;
    logic [c_ADC_BITS-1:0] r_sample;
    logic                  r_sample_valid;
    logic                  r_thrsh_out;

    logic                  w_run;
    logic                  w_sclk;
    logic                  w_capture;
    logic                  w_accept;
    logic                  w_done;
    logic [c_ADC_BITS-1:0] w_word;

    assign w_run    = (r_state == c_ST_SHIFT);
    assign w_accept = start && ADC_en && (r_state == c_ST_IDLE);
    assign w_done   = w_run && w_capture && (r_bit_idx == 4'd0);
    assign w_word   = {r_shift, r_adc_data_q};

    adc_spi_input_capture_sclk_phase_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_phase_gen (
        .clk       (dataclk),
        .rst       (reset),
        .i_run     (w_run),
        .o_sclk    (w_sclk),
        .o_capture (w_capture)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_CONV;
            c_ST_CONV:  if (r_conv_cnt == c_CONV_ONE) w_state_nxt = c_ST_EN;
            c_ST_EN:    w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: if (w_done) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_adc_data_q   <= 1'b0;
            r_conv_cnt     <= '0;
            r_bit_idx      <= 4'd0;
            r_shift        <= '0;
            r_cnv          <= c_CNV_IDLE;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_thrsh_out    <= 1'b0;
        end else begin
            r_adc_data_q <= ADC_DATA;
            r_state      <= w_state_nxt;
            // Pin/status registers follow the next state so they line up
            // exactly with the state register.
            r_cnv        <= (w_state_nxt == c_ST_CONV);
            r_busy       <= (w_state_nxt != c_ST_IDLE);
            r_overrun    <= start && ADC_en && (r_state != c_ST_IDLE);

            if (w_accept) begin
                r_conv_cnt <= c_CONV_LOAD;
            end else if (r_state == c_ST_CONV) begin
                r_conv_cnt <= r_conv_cnt - c_CONV_ONE;
            end

            if (r_state == c_ST_EN) begin
                r_bit_idx <= 4'd15;
            end else if (w_run && w_capture && (r_bit_idx != 4'd0)) begin
                r_bit_idx <= r_bit_idx - 4'd1;
            end

            if (w_run && w_capture) begin
                r_shift <= w_word[c_ADC_BITS-2:0];
            end

            r_sample_valid <= w_done;
            if (w_done) begin
                r_sample    <= w_word;
                r_thrsh_out <= thresh_hit(w_word, ADC_thrsh, ADC_thrsh_pol);
            end
        end
    end

    assign ADC_CNV       = r_cnv;
    assign ADC_SCLK      = w_sclk;
    assign sample        = r_sample;
    assign sample_valid  = r_sample_valid;
    assign busy          = r_busy;
    assign overrun       = r_overrun;
    assign ADC_thrsh_out = r_thrsh_out;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_spi_input_capture
// Description : Directed self-checking bench for adc_spi_input_capture with a
//               behavioural AD7980 SDO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_input_capture;

    logic        dataclk = 1'b0;
    logic        reset   = 1'b1;
    logic        ADC_en  = 1'b1;
    logic        start   = 1'b0;
    logic        ADC_CNV;
    logic        ADC_SCLK;
    logic        ADC_DATA;
    logic [15:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic [15:0] ADC_thrsh     = 16'h8000;
    logic        ADC_thrsh_pol = 1'b1;
    logic        ADC_thrsh_out;

    int n_cmp = 0;
    int n_err = 0;

    adc_spi_input_capture #(
        .CONV_CYCLES (60),
        .SCLK_HALF   (2)
    ) dut (
        .dataclk       (dataclk),
        .reset         (reset),
        .ADC_en        (ADC_en),
        .start         (start),
        .ADC_CNV       (ADC_CNV),
        .ADC_SCLK      (ADC_SCLK),
        .ADC_DATA      (ADC_DATA),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .overrun       (overrun),
        .ADC_thrsh     (ADC_thrsh),
        .ADC_thrsh_pol (ADC_thrsh_pol),
        .ADC_thrsh_out (ADC_thrsh_out)
    );

    always #5 dataclk = ~dataclk;

    // AD7980 model: MSB presented when CNV falls, next bit on each SCLK fall.
    logic [15:0] model_word = 16'h0000;
    logic [15:0] model_sr   = 16'h0000;
    always @(negedge ADC_CNV)  model_sr = model_word;
    always @(negedge ADC_SCLK) model_sr = {model_sr[14:0], 1'b0};
    assign ADC_DATA = model_sr[15];

    task automatic tick();
        @(posedge dataclk);
        #1;
    endtask

    // Issues a start in the current cycle (cycle 0 = T) and observes 135
    // cycles. Optional second start / reset pulse in a given cycle.
    task automatic run_frame(
        input  logic [15:0] word,
        input  int          second_start,
        input  int          rst_at,
        output int          v_cyc,
        output int          v_count,
        output int          ov_cyc,
        output int          cnv_first,
        output int          cnv_last,
        output int          rises,
        output logic [15:0] v_sample,
        output logic        v_flag,
        output logic        v_busy,
        output logic [2:0]  post_rst
    );
        logic prev_sclk;
        model_word = word;
        v_cyc = -1; v_count = 0; ov_cyc = -1; cnv_first = -1; cnv_last = -1;
        rises = 0; v_sample = 16'h0; v_flag = 1'b0; v_busy = 1'b1; post_rst = 3'b111;
        prev_sclk = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 135; c++) begin
            tick();
            start = (c == second_start);
            reset = (c == rst_at);
            if (ADC_CNV) begin
                if (cnv_first < 0) cnv_first = c;
                cnv_last = c;
            end
            if (ADC_SCLK && !prev_sclk) rises++;
            prev_sclk = ADC_SCLK;
            if (overrun && ov_cyc < 0) ov_cyc = c;
            if (c == rst_at + 1) post_rst = {ADC_CNV, ADC_SCLK, busy};
            if (sample_valid) begin
                v_count++;
                if (v_cyc < 0) begin
                    v_cyc = c; v_sample = sample; v_flag = ADC_thrsh_out; v_busy = busy;
                end
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            start = (c == 2);
            n_cmp++;
            if ({ADC_CNV, ADC_SCLK} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_pins cyc%0d: got cnv/sclk=%b required 00", c, {ADC_CNV, ADC_SCLK});
            end
        end
        start = 1'b0;
        n_cmp++;
        if ({sample, sample_valid, busy, overrun, ADC_thrsh_out} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got sample=%h v=%b busy=%b ov=%b thr=%b required all 0",
                     sample, sample_valid, busy, overrun, ADC_thrsh_out);
        end
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ADC_CNV, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_no_start: got cnv=%b busy=%b required 0 0", ADC_CNV, busy);
        end
    endtask

    task automatic test_basic_frame();
        int vc, vn, ovc, cf, cl, rs;
        logic [15:0] vs; logic vf, vb; logic [2:0] pr;
        ADC_thrsh = 16'h8000; ADC_thrsh_pol = 1'b1;
        run_frame(16'hA5C3, -1, -1, vc, vn, ovc, cf, cl, rs, vs, vf, vb, pr);
        n_cmp++; if (cf !== 1)   begin n_err++; $display("FAIL basic_cnv_first: got %0d required 1", cf); end
        n_cmp++; if (cl !== 60)  begin n_err++; $display("FAIL basic_cnv_last: got %0d required 60", cl); end
        n_cmp++; if (rs !== 16)  begin n_err++; $display("FAIL basic_sclk_rises: got %0d required 16", rs); end
        n_cmp++; if (vc !== 126) begin n_err++; $display("FAIL basic_valid_cycle: got %0d required 126", vc); end
        n_cmp++; if (vs !== 16'hA5C3) begin n_err++; $display("FAIL basic_sample: got %h required a5c3", vs); end
        n_cmp++; if (vb !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_valid: got %b required 0", vb); end
        n_cmp++; if (vn !== 1)   begin n_err++; $display("FAIL basic_valid_count: got %0d required 1", vn); end
        n_cmp++; if (vf !== 1'b1) begin n_err++; $display("FAIL basic_flag: got %b required 1", vf); end
        n_cmp++; if (sample !== 16'hA5C3) begin n_err++; $display("FAIL basic_sample_held: got %h required a5c3", sample); end
    endtask

    task automatic test_threshold();
        logic [15:0] words [4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8001};
        logic        pols  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        exp_f [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int vc, vn, ovc, cf, cl, rs;
        logic [15:0] vs; logic vf, vb; logic [2:0] pr;
        for (int i = 0; i < 4; i++) begin
            ADC_thrsh = 16'h8000; ADC_thrsh_pol = pols[i];
            run_frame(words[i], -1, -1, vc, vn, ovc, cf, cl, rs, vs, vf, vb, pr);
            n_cmp++;
            if (vs !== words[i]) begin
                n_err++; $display("FAIL thr_sample[%0d]: got %h required %h", i, vs, words[i]);
            end
            n_cmp++;
            if (vf !== exp_f[i]) begin
                n_err++; $display("FAIL thr_flag[%0d]: got %b required %b", i, vf, exp_f[i]);
            end
        end
        // Flag must hold between samples even when the threshold moves.
        ADC_thrsh = 16'hFFFF; ADC_thrsh_pol = 1'b1;
        tick(); tick();
        n_cmp++;
        if (ADC_thrsh_out !== 1'b0) begin
            n_err++; $display("FAIL thr_held: got %b required 0", ADC_thrsh_out);
        end
    endtask

    task automatic test_overrun();
        int vc, vn, ovc, cf, cl, rs;
        logic [15:0] vs; logic vf, vb; logic [2:0] pr;
        run_frame(16'h1234, 50, -1, vc, vn, ovc, cf, cl, rs, vs, vf, vb, pr);
        n_cmp++; if (ovc !== 51) begin n_err++; $display("FAIL ovr_cycle: got %0d required 51", ovc); end
        n_cmp++; if (vn !== 1)   begin n_err++; $display("FAIL ovr_valid_count: got %0d required 1", vn); end
        n_cmp++; if (vc !== 126) begin n_err++; $display("FAIL ovr_valid_cycle: got %0d required 126", vc); end
        n_cmp++; if (vs !== 16'h1234) begin n_err++; $display("FAIL ovr_sample: got %h required 1234", vs); end
        n_cmp++; if (cl !== 60)  begin n_err++; $display("FAIL ovr_cnv_last: got %0d required 60", cl); end
    endtask

    task automatic test_enable_gate();
        int vc, vn, ovc, cf, cl, rs;
        logic [15:0] vs; logic vf, vb; logic [2:0] pr;
        ADC_en = 1'b0;
        run_frame(16'hFFFF, 40, -1, vc, vn, ovc, cf, cl, rs, vs, vf, vb, pr);
        ADC_en = 1'b1;
        n_cmp++; if (cf !== -1) begin n_err++; $display("FAIL en_gate_cnv: got first=%0d required -1", cf); end
        n_cmp++; if (vn !== 0)  begin n_err++; $display("FAIL en_gate_valid: got %0d required 0", vn); end
        n_cmp++; if (ovc !== -1) begin n_err++; $display("FAIL en_gate_overrun: got %0d required -1", ovc); end
    endtask

    task automatic test_back_to_back();
        int v1, v2, ovc;
        logic [15:0] s1, s2;
        logic cnv_next;
        model_word = 16'h5A5A;
        v1 = -1; v2 = -1; ovc = -1; s1 = 16'h0; s2 = 16'h0; cnv_next = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            tick();
            start = 1'b0;
            if (v1 > 0 && c == v1 + 1) cnv_next = ADC_CNV;
            if (overrun && ovc < 0) ovc = c;
            if (sample_valid) begin
                if (v1 < 0) begin
                    v1 = c; s1 = sample; start = 1'b1; model_word = 16'h0001;
                end else if (v2 < 0) begin
                    v2 = c; s2 = sample;
                end
            end
        end
        start = 1'b0;
        n_cmp++; if (v1 !== 126) begin n_err++; $display("FAIL b2b_valid1: got %0d required 126", v1); end
        n_cmp++; if (s1 !== 16'h5A5A) begin n_err++; $display("FAIL b2b_sample1: got %h required 5a5a", s1); end
        n_cmp++; if (cnv_next !== 1'b1) begin n_err++; $display("FAIL b2b_cnv_t127: got %b required 1", cnv_next); end
        n_cmp++; if (v2 !== 252) begin n_err++; $display("FAIL b2b_valid2: got %0d required 252", v2); end
        n_cmp++; if (s2 !== 16'h0001) begin n_err++; $display("FAIL b2b_sample2: got %h required 0001", s2); end
        n_cmp++; if (ovc !== -1) begin n_err++; $display("FAIL b2b_overrun: got %0d required -1", ovc); end
    endtask

    task automatic test_reset_mid_frame();
        int vc, vn, ovc, cf, cl, rs;
        logic [15:0] vs; logic vf, vb; logic [2:0] pr;
        run_frame(16'hBEEF, -1, 80, vc, vn, ovc, cf, cl, rs, vs, vf, vb, pr);
        n_cmp++; if (pr !== 3'b000) begin n_err++; $display("FAIL rst_mid_pins: got cnv/sclk/busy=%b required 000", pr); end
        n_cmp++; if (vn !== 0) begin n_err++; $display("FAIL rst_mid_valid: got %0d required 0", vn); end
        n_cmp++; if (sample !== 16'h0000) begin n_err++; $display("FAIL rst_mid_sample: got %h required 0000", sample); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got busy=%b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_threshold();
        test_overrun();
        test_enable_gate();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
